// File: rtl/me_stage_pkg.sv
// me_stage_pkg
//   Shared pipeline definitions for the EX, ME and WB stages: bus widths,
//   field bit offsets of the EX->ME and ME->WB buses, and a helper that
//   assembles an ME->WB bus word from its fields.
package me_stage_pkg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  // EX->ME bus: {pc, alu_result, res_from_mem, gr_we, dest}
  localparam int EXME_BUS_W   = 71;
  localparam int EXB_DEST_LSB = 0;
  localparam int EXB_GR_WE    = 5;
  localparam int EXB_RES_MEM  = 6;
  localparam int EXB_ALU_LSB  = 7;
  localparam int EXB_PC_LSB   = 39;

  // ME->WB bus: {pc, final_result, gr_we, dest}
  localparam int MEWB_BUS_W   = 70;
  localparam int WBB_DEST_LSB = 0;
  localparam int WBB_GR_WE    = 5;
  localparam int WBB_RES_LSB  = 6;
  localparam int WBB_PC_LSB   = 38;

  function automatic logic [MEWB_BUS_W-1:0] pack_me_wb(
    input logic [PC_W-1:0]   pc,
    input logic [DATA_W-1:0] result,
    input logic              gr_we,
    input logic [DEST_W-1:0] dest
  );
    logic [MEWB_BUS_W-1:0] w;
    w = '0;
    w[WBB_PC_LSB +: PC_W]       = pc;
    w[WBB_RES_LSB +: DATA_W]    = result;
    w[WBB_GR_WE]                = gr_we;
    w[WBB_DEST_LSB +: DEST_W]   = dest;
    return w;
  endfunction

endpackage

// File: rtl/me_stage_if.sv
// Pipeline handshake interfaces around the ME stage.
//   ex_me_if : EX_to_ME_Valid / EX_to_ME_Bus from EX, ME_Allow_in back to EX.
//              master = EX side, slave = ME side.
//   me_wb_if : ME_to_WB_Valid / ME_to_WB_Bus from ME, WB_Allow_in back to ME.
//              master = ME side, slave = WB side.
interface ex_me_if import me_stage_pkg::*; #(parameter int W = EXME_BUS_W) ();
  logic         EX_to_ME_Valid;
  logic [W-1:0] EX_to_ME_Bus;
  logic         ME_Allow_in;

  modport master (output EX_to_ME_Valid, output EX_to_ME_Bus, input  ME_Allow_in);
  modport slave  (input  EX_to_ME_Valid, input  EX_to_ME_Bus, output ME_Allow_in);
endinterface

interface me_wb_if import me_stage_pkg::*; #(parameter int W = MEWB_BUS_W) ();
  logic         ME_to_WB_Valid;
  logic [W-1:0] ME_to_WB_Bus;
  logic         WB_Allow_in;

  modport master (output ME_to_WB_Valid, output ME_to_WB_Bus, input  WB_Allow_in);
  modport slave  (input  ME_to_WB_Valid, input  ME_to_WB_Bus, output WB_Allow_in);
endinterface

// File: rtl/me_stage_ld_hold_buf.sv
// ld_hold_buf
//   Captures load data from the SRAM. The SRAM returns data only in the
//   first cycle an instruction sits in ME, so that value is passed through
//   live and also stored; in any later (stalled) cycle the stored copy is used.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   latch       : ME is latching a new instruction at this edge
//   rdata       : data_sram_rdata
//   ld_data     : load data for the instruction currently in ME
module ld_hold_buf import me_stage_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              latch,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic              first_cycle;
  logic [DATA_W-1:0] rdata_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      first_cycle <= 1'b0;
      rdata_hold  <= '0;
    end else begin
      // A new latch re-arms first_cycle even while the previous one is set,
      // which keeps drain-and-fill cycles reading live data.
      first_cycle <= latch;
      if (first_cycle) rdata_hold <= rdata;
    end
  end

  assign ld_data = first_cycle ? rdata : rdata_hold;

endmodule

// File: rtl/me_stage.sv
// me_stage
//   Memory stage of the pipeline. Holds one instruction from EX, merges the
//   load data returned by the data SRAM, and hands the result to WB. No
//   memory request originates here; SRAM control stays in EX.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   ex_in            : EX->ME handshake (valid, bus in; ME_Allow_in out)
//   wb_out           : ME->WB handshake (valid, bus out; WB_Allow_in in)
//   data_sram_rdata  : load data, valid in the instruction's first ME cycle
//   ME_dest          : destination register for hazard detection, 0 if none
//   ME_fwd_data      : final result for forwarding
module me_stage import me_stage_pkg::*; #(
  parameter int EX_ME_BUS_W = EXME_BUS_W,
  parameter int ME_WB_BUS_W = MEWB_BUS_W
) (
  input  logic              clk,
  input  logic              reset,
  ex_me_if.slave            ex_in,
  me_wb_if.master           wb_out,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic [DEST_W-1:0] ME_dest,
  output logic [DATA_W-1:0] ME_fwd_data
);

  localparam logic ME_READY_GO = 1'b1;

  logic                   me_valid;
  logic [EX_ME_BUS_W-1:0] bus_r;
  logic                   allow_in;
  logic                   latch;
  logic [DATA_W-1:0]      ld_data;
  logic [DATA_W-1:0]      final_result;
  logic [ME_WB_BUS_W-1:0] wb_word;

  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] alu_result;
  logic              res_from_mem;
  logic              gr_we;
  logic [DEST_W-1:0] dest;

  // Depends only on state and WB, never on EX_to_ME_Valid.
  assign allow_in          = !me_valid || wb_out.WB_Allow_in;
  assign ex_in.ME_Allow_in = allow_in;
  assign latch             = allow_in && ex_in.EX_to_ME_Valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      me_valid <= 1'b0;
      bus_r    <= '0;
    end else begin
      if (allow_in) me_valid <= ex_in.EX_to_ME_Valid;
      if (latch)    bus_r    <= ex_in.EX_to_ME_Bus;
    end
  end

  assign pc           = bus_r[EXB_PC_LSB +: PC_W];
  assign alu_result   = bus_r[EXB_ALU_LSB +: DATA_W];
  assign res_from_mem = bus_r[EXB_RES_MEM];
  assign gr_we        = bus_r[EXB_GR_WE];
  assign dest         = bus_r[EXB_DEST_LSB +: DEST_W];

  ld_hold_buf u_ld_hold_buf (
    .clk     (clk),
    .reset   (reset),
    .latch   (latch),
    .rdata   (data_sram_rdata),
    .ld_data (ld_data)
  );

  assign final_result = res_from_mem ? ld_data : alu_result;
  assign wb_word      = pack_me_wb(pc, final_result, gr_we, dest);

  assign wb_out.ME_to_WB_Valid = me_valid && ME_READY_GO;
  assign wb_out.ME_to_WB_Bus   = wb_word;
  assign ME_dest               = (me_valid && gr_we) ? dest : '0;
  assign ME_fwd_data           = final_result;

endmodule

// File: tb/tb_me_stage.sv
// tb_me_stage
//   Scoreboard bench for me_stage: every offered instruction pushes its
//   expected ME->WB word; a negedge monitor pops and compares on each WB
//   handoff. Scenario tasks add inline checks on forwarding/hazard outputs.
module tb_me_stage;
  import me_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_sram_rdata;
  logic [4:0]  ME_dest;
  logic [31:0] ME_fwd_data;

  ex_me_if ex_bus ();
  me_wb_if wb_bus ();

  me_stage #(.EX_ME_BUS_W(71), .ME_WB_BUS_W(70)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_in           (ex_bus),
    .wb_out          (wb_bus),
    .data_sram_rdata (data_sram_rdata),
    .ME_dest         (ME_dest),
    .ME_fwd_data     (ME_fwd_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [69:0] exp_q[$];
  logic [69:0] mon_exp;

  function automatic logic [69:0] wb_word(input logic [31:0] pc, input logic [31:0] res,
                                          input logic we, input logic [4:0] d);
    return {pc, res, we, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction from EX and record what WB must eventually see.
  task automatic offer(input logic [31:0] pc, input logic [31:0] alu, input logic mem,
                       input logic we, input logic [4:0] d, input logic [31:0] ld_val);
    ex_bus.EX_to_ME_Valid = 1'b1;
    ex_bus.EX_to_ME_Bus   = {pc, alu, mem, we, d};
    exp_q.push_back(wb_word(pc, mem ? ld_val : alu, we, d));
  endtask

  always @(negedge clk) begin
    if (!reset && wb_bus.ME_to_WB_Valid && wb_bus.WB_Allow_in) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_handoff: got %h, required no handoff", wb_bus.ME_to_WB_Bus);
      end else begin
        mon_exp = exp_q.pop_front();
        if (wb_bus.ME_to_WB_Bus !== mon_exp) begin
          errors++;
          $display("FAIL wb_handoff: got %h, required %h", wb_bus.ME_to_WB_Bus, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (wb_bus.ME_to_WB_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid_during: got %b, required 0", wb_bus.ME_to_WB_Valid);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_bus.ME_to_WB_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, required 0", wb_bus.ME_to_WB_Valid);
    end
    checks++;
    if (ME_dest !== 5'd0) begin
      errors++; $display("FAIL reset_dest: got %0d, required 0", ME_dest);
    end
    checks++;
    if (ex_bus.ME_Allow_in !== 1'b1) begin
      errors++; $display("FAIL reset_allow_in: got %b, required 1", ex_bus.ME_Allow_in);
    end
  endtask

  task automatic test_alu();
    wb_bus.WB_Allow_in = 1'b1;
    offer(32'h1C00_0000, 32'h1234_5678, 1'b0, 1'b1, 5'd5, 32'h0);
    tick();
    ex_bus.EX_to_ME_Valid = 1'b0;
    data_sram_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (ME_dest !== 5'd5) begin
      errors++; $display("FAIL alu_dest: got %0d, required 5", ME_dest);
    end
    checks++;
    if (ME_fwd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL alu_fwd: got %h, required 12345678", ME_fwd_data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (wb_bus.ME_to_WB_Valid !== 1'b0) begin
      errors++; $display("FAIL alu_empty_valid: got %b, required 0", wb_bus.ME_to_WB_Valid);
    end
    checks++;
    if (ME_dest !== 5'd0) begin
      errors++; $display("FAIL alu_empty_dest: got %0d, required 0", ME_dest);
    end
  endtask

  task automatic test_load_stall();
    wb_bus.WB_Allow_in = 1'b0;
    offer(32'h1C00_0010, 32'h8000_0040, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
    tick();
    ex_bus.EX_to_ME_Valid = 1'b0;
    data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (ME_fwd_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL load_first_cycle: got %h, required deadbeef", ME_fwd_data);
    end
    checks++;
    if (ex_bus.ME_Allow_in !== 1'b0) begin
      errors++; $display("FAIL load_stall_allow_in: got %b, required 0", ex_bus.ME_Allow_in);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = (i == 0) ? 32'h0 : $urandom;
      @(negedge clk);
      checks++;
      if (ME_fwd_data !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL load_stall_hold[%0d]: got %h, required deadbeef", i, ME_fwd_data);
      end
    end
    tick();
    data_sram_rdata = 32'h0;
    wb_bus.WB_Allow_in = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (wb_bus.ME_to_WB_Valid !== 1'b0) begin
      errors++; $display("FAIL load_after_valid: got %b, required 0", wb_bus.ME_to_WB_Valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4] = '{32'h1C00_0100, 32'h1C00_0104, 32'h1C00_0108, 32'h1C00_010C};
    logic [31:0] alus[4] = '{32'h0000_0011, 32'h8000_0200, 32'h8000_0204, 32'h0000_0044};
    logic        mems[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] lds [4] = '{32'h0, 32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'h0};
    wb_bus.WB_Allow_in = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) offer(pcs[i], alus[i], mems[i], 1'b1, 5'(10 + i), lds[i]);
      else       ex_bus.EX_to_ME_Valid = 1'b0;
      if (i > 0) begin
        data_sram_rdata = lds[i-1];
        @(negedge clk);
        checks++;
        if (wb_bus.ME_to_WB_Valid !== 1'b1) begin
          errors++; $display("FAIL b2b_valid[%0d]: got %b, required 1", i-1, wb_bus.ME_to_WB_Valid);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (wb_bus.ME_to_WB_Valid !== 1'b0) begin
      errors++; $display("FAIL b2b_tail_valid: got %b, required 0", wb_bus.ME_to_WB_Valid);
    end
  endtask

  task automatic test_drain_fill();
    wb_bus.WB_Allow_in = 1'b0;
    offer(32'h1C00_0200, 32'h8000_0300, 1'b1, 1'b1, 5'd8, 32'hCAFE_F00D);
    tick();
    ex_bus.EX_to_ME_Valid = 1'b0;
    data_sram_rdata = 32'hCAFE_F00D;
    tick();
    data_sram_rdata = $urandom;
    offer(32'h1C00_0204, 32'h0BAD_C0DE, 1'b0, 1'b1, 5'd9, 32'h0);
    wb_bus.WB_Allow_in = 1'b1;
    @(negedge clk);
    checks++;
    if (ME_fwd_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL df_load_held: got %h, required cafef00d", ME_fwd_data);
    end
    checks++;
    if (ex_bus.ME_Allow_in !== 1'b1) begin
      errors++; $display("FAIL df_allow_in: got %b, required 1", ex_bus.ME_Allow_in);
    end
    tick();
    ex_bus.EX_to_ME_Valid = 1'b0;
    data_sram_rdata = $urandom;
    @(negedge clk);
    checks++;
    if (ME_fwd_data !== 32'h0BAD_C0DE) begin
      errors++; $display("FAIL df_alu_fwd: got %h, required 0badc0de", ME_fwd_data);
    end
    tick();
    // Load replaced by load on a release cycle: second load must see live data.
    wb_bus.WB_Allow_in = 1'b0;
    offer(32'h1C00_0208, 32'h8000_0400, 1'b1, 1'b1, 5'd10, 32'h1111_1111);
    tick();
    ex_bus.EX_to_ME_Valid = 1'b0;
    data_sram_rdata = 32'h1111_1111;
    tick();
    data_sram_rdata = $urandom;
    offer(32'h1C00_020C, 32'h8000_0404, 1'b1, 1'b1, 5'd11, 32'h2222_2222);
    wb_bus.WB_Allow_in = 1'b1;
    tick();
    ex_bus.EX_to_ME_Valid = 1'b0;
    data_sram_rdata = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (ME_fwd_data !== 32'h2222_2222) begin
      errors++; $display("FAIL df_load_live: got %h, required 22222222", ME_fwd_data);
    end
    tick();
    data_sram_rdata = $urandom;
  endtask

  task automatic test_reset_stall();
    wb_bus.WB_Allow_in = 1'b0;
    offer(32'h1C00_0300, 32'h8000_0500, 1'b1, 1'b1, 5'd7, 32'h7777_7777);
    tick();
    ex_bus.EX_to_ME_Valid = 1'b0;
    data_sram_rdata = 32'h7777_7777;
    @(negedge clk);
    checks++;
    if (ME_dest !== 5'd7) begin
      errors++; $display("FAIL rs_dest_before: got %0d, required 7", ME_dest);
    end
    tick();
    data_sram_rdata = $urandom;
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    wb_bus.WB_Allow_in = 1'b1;
    @(negedge clk);
    checks++;
    if (ME_dest !== 5'd0) begin
      errors++; $display("FAIL rs_dest_after: got %0d, required 0", ME_dest);
    end
    checks++;
    if (ex_bus.ME_Allow_in !== 1'b1) begin
      errors++; $display("FAIL rs_allow_in: got %b, required 1", ex_bus.ME_Allow_in);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wb_bus.ME_to_WB_Valid !== 1'b0) begin
        errors++; $display("FAIL rs_valid[%0d]: got %b, required 0", i, wb_bus.ME_to_WB_Valid);
      end
      tick();
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset                 = 1'b1;
    ex_bus.EX_to_ME_Valid = 1'b0;
    ex_bus.EX_to_ME_Bus   = '0;
    wb_bus.WB_Allow_in    = 1'b1;
    data_sram_rdata       = '0;

    test_reset();
    test_alu();
    test_load_stall();
    test_back_to_back();
    test_drain_fill();
    test_reset_stall();

    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
